// File: rtl/crossbar_nxn_arb.sv
// N x N crossbar: one round-robin arbiter and one output register per output port.
// Each output can drain and refill in the same cycle; out-of-range destinations are dropped and flagged.
module crossbar_nxn_arb #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N*SEL_W-1:0]   in_dest,
    output logic [N-1:0]         in_ready,
    output logic [N-1:0]         out_valid,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [N*SEL_W-1:0]   out_src,
    input  logic [N-1:0]         out_ready,
    output logic                 err_dest
);

    localparam logic [SEL_W:0] NUM = (SEL_W + 1)'(N);

    logic [N-1:0]     bad;
    logic [N-1:0]     free;
    logic [N-1:0]     gnt_any;
    logic [SEL_W-1:0] gnt_idx [N];
    logic [N-1:0]     gnt     [N];
    logic [SEL_W-1:0] ptr     [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bad[i] = ({1'b0, in_dest[i*SEL_W +: SEL_W]} >= NUM);
        end
        for (int o = 0; o < N; o++) begin
            free[o] = !out_valid[o] || out_ready[o];
        end
    end

    // Search upward from ptr[o], wrapping at N, first matching requester wins.
    always_comb begin
        logic [SEL_W:0]   sum;
        logic [SEL_W-1:0] idx;
        sum = '0;
        idx = '0;
        for (int o = 0; o < N; o++) begin
            gnt_any[o] = 1'b0;
            gnt_idx[o] = '0;
            gnt[o]     = '0;
            for (int k = 0; k < N; k++) begin
                sum = {1'b0, ptr[o]} + (SEL_W + 1)'(k);
                if (sum >= NUM) begin
                    sum = sum - NUM;
                end
                idx = sum[SEL_W-1:0];
                if (!gnt_any[o] && !rst && free[o] && in_valid[idx] &&
                    in_dest[idx*SEL_W +: SEL_W] == SEL_W'(o)) begin
                    gnt_any[o]   = 1'b1;
                    gnt_idx[o]   = idx;
                    gnt[o][idx]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_ready[i] = bad[i];
            for (int o = 0; o < N; o++) begin
                in_ready[i] = in_ready[i] | gnt[o][i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            out_src   <= '0;
            err_dest  <= 1'b0;
            for (int o = 0; o < N; o++) begin
                ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                if (gnt_any[o]) begin
                    out_valid[o]                  <= 1'b1;
                    out_data[o*WIDTH +: WIDTH]    <= in_data[gnt_idx[o]*WIDTH +: WIDTH];
                    out_src[o*SEL_W +: SEL_W]     <= gnt_idx[o];
                    ptr[o] <= (gnt_idx[o] == SEL_W'(N - 1)) ? '0 : gnt_idx[o] + 1'b1;
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
            if (|(in_valid & bad)) begin
                err_dest <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crossbar_nxn_arb.sv
// Bench for crossbar_nxn_arb: directed scenarios plus random traffic,
// checked through per-output expectation queues against a behavioural model.
module tb_crossbar_nxn_arb;

    localparam int N = 4;
    localparam int W = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid, in_ready, out_valid, out_ready;
    logic [N*W-1:0] in_data, out_data;
    logic [N*S-1:0] in_dest, out_src;
    logic           err_dest;

    logic [2:0]     v3, r3, ov3, or3;
    logic [11:0]    d3, od3;
    logic [5:0]     de3, os3;
    logic           err3;

    int tests = 0;
    int fails = 0;

    bit             mv   [N];
    int             mptr [N];
    logic [W+S-1:0] q    [N][$];
    logic [N-1:0]   acc = '0;
    logic [W+S-1:0] mon_e;

    crossbar_nxn_arb #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .err_dest(err_dest)
    );

    crossbar_nxn_arb #(.WIDTH(4), .N(3)) u3 (
        .clk(clk), .rst(rst),
        .in_valid(v3), .in_data(d3), .in_dest(de3),
        .in_ready(r3),
        .out_valid(ov3), .out_data(od3), .out_src(os3),
        .out_ready(or3), .err_dest(err3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            mv[o]   = 1'b0;
            mptr[o] = 0;
            q[o].delete();
        end
        acc = '0;
    endtask

    // Called right after a falling edge, once inputs for this cycle are set.
    task automatic step();
        logic [N-1:0] er;
        int  g;
        bit  gf;
        int  i;
        #1;
        er = '0;
        g  = 0;
        for (int o = 0; o < N; o++) begin
            chk("out_valid", out_valid[o], mv[o]);
            gf = 1'b0;
            if (!mv[o] || out_ready[o]) begin
                for (int k = 0; k < N; k++) begin
                    i = (mptr[o] + k) % N;
                    if (!gf && in_valid[i] && in_dest[i*S +: S] == S'(o)) begin
                        gf = 1'b1;
                        g  = i;
                    end
                end
            end
            if (gf) begin
                er[g] = 1'b1;
                q[o].push_back({in_data[g*W +: W], S'(g)});
                mptr[o] = (g + 1) % N;
                mv[o]   = 1'b1;
            end else if (out_ready[o]) begin
                mv[o] = 1'b0;
            end
        end
        chk("in_ready", in_ready, er);
        acc = in_valid & er;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = '0;
            out_ready = '1;
            step();
        end
    endtask

    task automatic perm(input logic [N-1:0] rdy);
        in_valid  = '1;
        in_dest   = {2'd0, 2'd1, 2'd2, 2'd3};
        in_data   = 16'hDCBA;
        out_ready = rdy;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                for (int o = 0; o < N; o++) begin
                    if (out_valid[o] && out_ready[o]) begin
                        chk("sb_pending", 64'(q[o].size() > 0), 1);
                        if (q[o].size() > 0) begin
                            mon_e = q[o].pop_front();
                            chk("sb_data", out_data[o*W +: W], mon_e[W+S-1:S]);
                            chk("sb_src", out_src[o*S +: S], mon_e[S-1:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 4'b0011;
        in_data   = '0;
        in_dest   = '0;
        out_ready = '1;
        v3  = '0;
        d3  = '0;
        de3 = '0;
        or3 = '1;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_err", err_dest, 0);
        chk("rst_in_ready", in_ready, 0);

        @(negedge clk);
        rst = 1'b0;
        perm('1);
        step();
        chk("perm_ready", in_ready, 4'hF);
        @(negedge clk);
        in_valid = '0;
        step();
        chk("perm_data", out_data, 16'hABCD);
        chk("perm_src", out_src, 8'h1B);
        idle(1);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid  = 4'b0111;
            in_dest   = {2'd0, 2'd1, 2'd1, 2'd1};
            in_data   = 16'h0321;
            out_ready = '1;
            step();
            chk("rr_grant", in_ready, 4'b0001 << (k % 3));
            if (k > 0) chk("rr_src", out_src[2 +: 2], (k - 1) % 3);
        end
        idle(2);

        @(negedge clk);
        in_valid = 4'b0010;
        in_dest  = 8'b00_00_10_00;
        in_data  = 16'h0050;
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_data   = 16'h0060;
            out_ready = 4'b1011;
            step();
            chk("bp_ready", in_ready[1], 0);
            chk("bp_hold", out_data[8 +: 4], 4'h5);
            chk("bp_valid", out_valid[2], 1);
        end
        @(negedge clk);
        out_ready = '1;
        step();
        chk("bp_release", in_ready[1], 1);
        @(negedge clk);
        in_valid = '0;
        step();
        chk("bp_new", out_data[8 +: 4], 4'h6);
        chk("bp_nobubble", out_valid[2], 1);
        idle(2);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || acc[i]) begin
                    in_valid[i]      = 1'($urandom);
                    in_dest[i*S +: S] = S'($urandom);
                    in_data[i*W +: W] = W'($urandom);
                end
                out_ready[i] = ($urandom_range(3) != 0);
            end
            step();
        end
        idle(3);
        for (int o = 0; o < N; o++) chk("drain_empty", q[o].size(), 0);

        @(negedge clk);
        v3  = 3'b001;
        de3 = 6'b000011;
        d3  = 12'h00F;
        #1;
        chk("bad_ready", r3[0], 1);
        @(negedge clk);
        v3 = '0;
        #1;
        chk("bad_err", err3, 1);
        chk("bad_noout", ov3, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("bad_sticky", err3, 1);

        @(negedge clk);
        perm('0);
        step();
        @(negedge clk);
        in_valid = '0;
        step();
        #4;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_src", out_src, 0);
        chk("mid_rst_err3", err3, 0);
        model_reset();
        in_valid = 4'b1100;
        in_dest  = '0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = '1;
        step();
        chk("rst_first", in_ready, 4'b0100);
        @(negedge clk);
        in_valid = 4'b1000;
        step();
        chk("rst_second", in_ready, 4'b1000);
        idle(3);
        for (int o = 0; o < N; o++) chk("final_empty", q[o].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
